mem_requester: RTL

- Initiator side of the instruction/data memory interface.
- Accepts single-word (16-bit) or double-word (32-bit) load/store requests from the MEM stage or fetch logic, and sequences them into one or two word accesses on the memory's read/write ports.
- Captures read data and returns one response per request.
- Double-word accesses serve PC push/pop and 32-bit immediate fetch.

---
 rtl/mem_requester_pkg.sv | 25 ++
 rtl/mem_requester.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mem_requester_pkg.sv
// +-----------------------------------------------------------------------------
// | mem_requester_pkg : shared types and sizes for the memory requester path
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package mem_requester_pkg;

  // Default widths shared with the memory and the MEM stage
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 16;

  localparam logic SZ_WORD  = 1'b0;
  localparam logic SZ_DWORD = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W0   = 2'd1,
    W1   = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_requester.sv
// +-----------------------------------------------------------------------------
// | mem_requester : sequences 1- or 2-word loads/stores onto the memory ports.
// | Optional macro MEM_REQ_ALIGN_CHECK_EN adds rsp_err for odd-address doubles.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module mem_requester
  import mem_requester_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic                req_dbl,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rsp_rdata,
`ifdef MEM_REQ_ALIGN_CHECK_EN
  output logic                rsp_err,
`endif
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr_rd,
  output logic [ADDR_W-1:0]   mem_addr_wr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t            state;
  logic              we;
  logic              dbl;
  logic [DATA_W-1:0] wdata_hi;
  logic [DATA_W-1:0] rdata_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr_rd <= '0;
      mem_addr_wr <= '0;
      mem_wdata   <= '0;
      we          <= 1'b0;
      dbl         <= SZ_WORD;
      wdata_hi    <= '0;
      rdata_lo    <= '0;
`ifdef MEM_REQ_ALIGN_CHECK_EN
      rsp_err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we        <= req_we;
            dbl       <= req_dbl;
            wdata_hi  <= req_wdata[2*DATA_W-1:DATA_W];
            req_ready <= 1'b0;
`ifdef MEM_REQ_ALIGN_CHECK_EN
            if (req_dbl && req_addr[0]) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else
`endif
            begin
              state       <= W0;
              mem_rd      <= ~req_we;
              mem_wr      <= req_we;
              mem_addr_rd <= req_addr;
              mem_addr_wr <= req_addr;
              if (req_we) mem_wdata <= req_wdata[DATA_W-1:0];
            end
          end
        end
        W0: begin
          if (dbl == SZ_WORD) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            if (!we) rsp_rdata <= {{DATA_W{1'b0}}, mem_rdata};
          end else begin
            // Low half parks here so rsp_rdata only changes when the load completes
            state       <= W1;
            rdata_lo    <= mem_rdata;
            mem_addr_rd <= mem_addr_rd + ADDR_W'(1);
            mem_addr_wr <= mem_addr_rd + ADDR_W'(1);
            if (we) mem_wdata <= wdata_hi;
          end
        end
        W1: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          mem_rd    <= 1'b0;
          mem_wr    <= 1'b0;
          if (!we) rsp_rdata <= {mem_rdata, rdata_lo};
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
`ifdef MEM_REQ_ALIGN_CHECK_EN
          rsp_err   <= 1'b0;
`endif
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          mem_rd    <= 1'b0;
          mem_wr    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
